// File: rtl/csr_ctrl.sv
// Zicsr read-modify-write sequencer with machine-mode CSR storage and 64-bit cycle counter.
// Optional: define CSR_INSTRET_EN to add the instret counter and its four addresses.
module csr_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_adr_i,
  input  logic [31:0] rs1_val_i,
  input  logic [4:0]  uimm_i,
  input  logic        retire_i,
  output logic        ack_o,
  output logic [31:0] rd_val_o,
  output logic        illegal_o
);
  localparam logic [11:0] A_MSCRATCH = 12'h340, A_MTVEC   = 12'h305, A_MEPC    = 12'h341,
                          A_MCAUSE   = 12'h342, A_MCYCLE  = 12'hB00, A_MCYCLEH = 12'hB80,
                          A_CYCLE    = 12'hC00, A_CYCLEH  = 12'hC80;
`ifdef CSR_INSTRET_EN
  localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82,
                          A_INSTRET  = 12'hC02, A_INSTRETH  = 12'hC82;
`endif

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MODIFY, S_WRITE, S_DONE} state_e;
  state_e state_q, state_d;

  logic [1:0]  op_q, op_d;
  logic [11:0] adr_q, adr_d;
  logic [31:0] opnd_q, opnd_d, old_q, old_d, new_q, new_d;
  logic        sup_q, sup_d, ill_q, ill_d;
  logic        ack_q, ack_d, illegal_q, illegal_d;
  logic [31:0] rd_val_q, rd_val_d;
  logic [31:0] mscratch_q, mscratch_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] cycle_q, cycle_d;
`ifdef CSR_INSTRET_EN
  logic [63:0] instret_q, instret_d;
`else
  logic        unused_retire;
  assign unused_retire = retire_i;
`endif
  logic [31:0] rdata;
  logic        mapped;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_i) state_d = S_READ;
      S_READ:   state_d = S_MODIFY;
      S_MODIFY: state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (adr_q)
      A_MSCRATCH:        rdata = mscratch_q;
      A_MTVEC:           rdata = mtvec_q;
      A_MEPC:            rdata = mepc_q;
      A_MCAUSE:          rdata = mcause_q;
      A_MCYCLE, A_CYCLE:   rdata = cycle_q[31:0];
      A_MCYCLEH, A_CYCLEH: rdata = cycle_q[63:32];
`ifdef CSR_INSTRET_EN
      A_MINSTRET, A_INSTRET:   rdata = instret_q[31:0];
      A_MINSTRETH, A_INSTRETH: rdata = instret_q[63:32];
`endif
      default:           mapped = 1'b0;
    endcase
  end

  always_comb begin
    op_d = op_q; adr_d = adr_q; opnd_d = opnd_q; sup_d = sup_q;
    old_d = old_q; new_d = new_q; ill_d = ill_q;
    mscratch_d = mscratch_q; mtvec_d = mtvec_q; mepc_d = mepc_q; mcause_d = mcause_q;
    cycle_d = cycle_q + 64'd1;
`ifdef CSR_INSTRET_EN
    instret_d = instret_q + {63'd0, retire_i};
`endif
    if (state_q == S_IDLE && req_i) begin
      op_d   = funct3_i[1:0];
      adr_d  = csr_adr_i;
      opnd_d = funct3_i[2] ? {27'b0, uimm_i} : rs1_val_i;
      sup_d  = (funct3_i[1:0] != 2'b01) && (uimm_i == 5'd0);
    end
    if (state_q == S_READ) old_d = rdata;
    if (state_q == S_MODIFY) begin
      case (op_q)
        2'b01:   new_d = opnd_q;
        2'b10:   new_d = old_q | opnd_q;
        2'b11:   new_d = old_q & ~opnd_q;
        default: new_d = old_q;
      endcase
      // funct3 low bits 00 is not a CSR op; reject rather than guess
      ill_d = !mapped || (op_q == 2'b00) || ((adr_q[11:10] == 2'b11) && !sup_q);
    end
    // counter writes replace the increment for that cycle, so no carry crosses halves
    if (state_q == S_WRITE && !ill_q && !sup_q) begin
      case (adr_q)
        A_MSCRATCH: mscratch_d = new_q;
        A_MTVEC:    mtvec_d    = {new_q[31:2], 2'b00};
        A_MEPC:     mepc_d     = {new_q[31:2], 2'b00};
        A_MCAUSE:   mcause_d   = new_q;
        A_MCYCLE:   cycle_d    = {cycle_q[63:32], new_q};
        A_MCYCLEH:  cycle_d    = {new_q, cycle_q[31:0]};
`ifdef CSR_INSTRET_EN
        A_MINSTRET:  instret_d = {instret_q[63:32], new_q};
        A_MINSTRETH: instret_d = {new_q, instret_q[31:0]};
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_d     = (state_q == S_DONE);
    rd_val_d  = rd_val_q;
    illegal_d = illegal_q;
    if (state_q == S_DONE) begin
      rd_val_d  = ill_q ? '0 : old_q;
      illegal_d = ill_q;
    end
  end

  assign ack_o     = ack_q;
  assign rd_val_o  = rd_val_q;
  assign illegal_o = illegal_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q <= '0; adr_q <= '0; opnd_q <= '0; sup_q <= 1'b0;
      old_q <= '0; new_q <= '0; ill_q <= 1'b0;
      ack_q <= 1'b0; rd_val_q <= '0; illegal_q <= 1'b0;
      mscratch_q <= '0; mepc_q <= '0; mcause_q <= '0;
      mtvec_q <= {MTVEC_RESET[31:2], 2'b00};
      cycle_q <= '0;
`ifdef CSR_INSTRET_EN
      instret_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d; adr_q <= adr_d; opnd_q <= opnd_d; sup_q <= sup_d;
      old_q <= old_d; new_q <= new_d; ill_q <= ill_d;
      ack_q <= ack_d; rd_val_q <= rd_val_d; illegal_q <= illegal_d;
      mscratch_q <= mscratch_d; mtvec_q <= mtvec_d; mepc_q <= mepc_d; mcause_q <= mcause_d;
      cycle_q <= cycle_d;
`ifdef CSR_INSTRET_EN
      instret_q <= instret_d;
`endif
    end
  end
endmodule

// File: tb/tb_csr_ctrl.sv
// Directed-vector bench for csr_ctrl: RMW ops, masking, counter wrap, illegal access, reset abort.
module tb_csr_ctrl;
  logic        clk_i = 1'b0, rst_i = 1'b1, req_i = 1'b0, retire_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [11:0] csr_adr_i = '0;
  logic [31:0] rs1_val_i = '0;
  logic [4:0]  uimm_i = '0;
  logic        ack_o, illegal_o;
  logic [31:0] rd_val_o;
  int n_vec = 0, n_err = 0;

  csr_ctrl #(.MTVEC_RESET(32'h0000_1003)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .funct3_i(funct3_i),
    .csr_adr_i(csr_adr_i), .rs1_val_i(rs1_val_i), .uimm_i(uimm_i),
    .retire_i(retire_i), .ack_o(ack_o), .rd_val_o(rd_val_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Starts at a negedge, returns at the negedge inside the ack cycle.
  task automatic csr_op(input logic [2:0] f3, input logic [11:0] adr, input logic [31:0] rs1,
                        input logic [4:0] uimm, output logic [31:0] rd, output logic ill,
                        output int lat);
    req_i = 1'b1; funct3_i = f3; csr_adr_i = adr; rs1_val_i = rs1; uimm_i = uimm;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      if (ack_o) break;
    end
    chk("ack", 32'(ack_o), 32'd1);
    rd = rd_val_o;
    ill = illegal_o;
  endtask

  task automatic rd_csr(input logic [11:0] adr, output logic [31:0] rd, output logic ill);
    int lat;
    csr_op(3'b010, adr, 32'hFFFF_FFFF, 5'd0, rd, ill, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        ill;
    int          lat;
    bit          ack_seen;

    repeat (3) @(negedge clk_i);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_ill", 32'(illegal_o), 32'd0);
    chk("rst_rd", rd_val_o, 32'd0);
    rst_i = 1'b0;

    csr_op(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd1, rd, ill, lat);
    chk("rw_lat", 32'(lat), 32'd4);
    chk("rw_rd", rd, 32'd0);
    chk("rw_ill", 32'(ill), 32'd0);
    csr_op(3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0, rd, ill, lat);
    chk("rs0_rd", rd, 32'hDEAD_BEEF);
    @(posedge clk_i); @(negedge clk_i);
    chk("rd_hold", rd_val_o, 32'hDEAD_BEEF);
    chk("ack_pulse", 32'(ack_o), 32'd0);
    rd_csr(12'h340, rd, ill);
    chk("rs0_nowr", rd, 32'hDEAD_BEEF);

    csr_op(3'b001, 12'h340, 32'h0000_00F0, 5'd1, rd, ill, lat);
    chk("rw2_rd", rd, 32'hDEAD_BEEF);
    csr_op(3'b110, 12'h340, 32'd0, 5'h0F, rd, ill, lat);
    chk("rsi_rd", rd, 32'h0000_00F0);
    csr_op(3'b111, 12'h340, 32'd0, 5'h03, rd, ill, lat);
    chk("rci_rd", rd, 32'h0000_00FF);
    rd_csr(12'h340, rd, ill);
    chk("rci_val", rd, 32'h0000_00FC);

    csr_op(3'b001, 12'h305, 32'h8000_0003, 5'd1, rd, ill, lat);
    chk("mtvec_rst", rd, 32'h0000_1000);
    rd_csr(12'h305, rd, ill);
    chk("mtvec_mask", rd, 32'h8000_0000);
    csr_op(3'b001, 12'h341, 32'h8000_0003, 5'd1, rd, ill, lat);
    chk("mepc_rst", rd, 32'd0);
    rd_csr(12'h341, rd, ill);
    chk("mepc_mask", rd, 32'h8000_0000);

    csr_op(3'b010, 12'h7FF, 32'h0000_0001, 5'd1, rd, ill, lat);
    chk("unmap_ill", 32'(ill), 32'd1);
    chk("unmap_rd", rd, 32'd0);
    rd_csr(12'h340, rd, ill);
    chk("unmap_keep", rd, 32'h0000_00FC);
    chk("unmap_ok", 32'(ill), 32'd0);

    rd_csr(12'hB02, rd, ill);
`ifdef CSR_INSTRET_EN
    chk("instret_ill", 32'(ill), 32'd0);
`else
    chk("instret_ill", 32'(ill), 32'd1);
`endif

    // Chained ops: each accepted exactly 5 cycles after the previous one.
    csr_op(3'b001, 12'hB80, 32'd0, 5'd1, rd, ill, lat);
    chk("mcych_ill", 32'(ill), 32'd0);
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFE, 5'd1, rd, ill, lat);
    chk("mcyc_ill", 32'(ill), 32'd0);
    rd_csr(12'hC00, rd, ill);
    chk("wrap_lo", rd, 32'd0);
    rd_csr(12'hC80, rd, ill);
    chk("wrap_hi", rd, 32'd1);
    csr_op(3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0, rd, ill, lat);
    chk("ro_rs0_ill", 32'(ill), 32'd0);
    chk("ro_rs0_val", rd, 32'd10);
    csr_op(3'b001, 12'hC00, 32'd0, 5'd1, rd, ill, lat);
    chk("ro_wr_ill", 32'(ill), 32'd1);
    chk("ro_wr_rd", rd, 32'd0);
    rd_csr(12'hC00, rd, ill);
    chk("ro_wr_keep", rd, 32'd20);

    // Reset asserted while the op sits in MODIFY.
    req_i = 1'b1; funct3_i = 3'b001; csr_adr_i = 12'h340; rs1_val_i = 32'h1234; uimm_i = 5'd2;
    @(posedge clk_i); @(negedge clk_i);
    req_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    ack_seen = 1'b0;
    repeat (8) begin
      @(posedge clk_i); @(negedge clk_i);
      if (ack_o) ack_seen = 1'b1;
    end
    chk("abort_noack", 32'(ack_seen), 32'd0);
    rd_csr(12'h340, rd, ill);
    chk("abort_mscr", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
